fetch_controller: RTL and testbench

- Sequences the instruction memory: holds the PC and drives the 11-bit word address into the combinational-read instruction memory.
- Captures each returned word into a small in-order buffer and hands instruction+PC to decode over a valid/ready handshake.
- Handles branch/jump redirects with a buffer flush, and halts fetch on EBREAK.
- Sits between instructions_memory and the decode stage.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_controller_if.sv | 38 +++
 rtl/fetch_buffer.sv | 76 +++++++
 rtl/fetch_controller.sv | 129 ++++++++++++
 tb/tb_fetch_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch slice
package fetch_pkg;

  localparam int IMEM_ADDR_W = 11;
  localparam int XLEN        = 32;
  localparam logic [XLEN-1:0] DEFAULT_HALT_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - control, imem, decode and redirect signals of the fetch stage
// FETCH_PERF_CNT_EN adds the fetch/stall counter outputs.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic                   start;
  logic [IMEM_ADDR_W-1:0] imem_address;
  logic [XLEN-1:0]        imem_read_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_instr;
  logic [XLEN-1:0]        out_pc;
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   halted;
  logic                   misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]            fetch_count;
  logic [31:0]            stall_count;
`endif

  modport master (
    input  start, imem_read_data, out_ready, redirect_valid, redirect_pc,
    output imem_address, out_valid, out_instr, out_pc, halted, misalign_err
`ifdef FETCH_PERF_CNT_EN
    , output fetch_count, stall_count
`endif
  );

  modport slave (
    output start, imem_read_data, out_ready, redirect_valid, redirect_pc,
    input  imem_address, out_valid, out_instr, out_pc, halted, misalign_err
`ifdef FETCH_PERF_CNT_EN
    , input fetch_count, stall_count
`endif
  );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order FIFO of fetched {instr, pc} entries with flush
// The head is registered so it can show a word pushed into an empty buffer on the next cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_head;

  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_drained;
  fetch_entry_t     w_head_nxt;

  assign w_rd_nxt    = i_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
  assign w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
  assign w_drained   = (r_count == '0) || ((r_count == CNT_W'(1)) && i_pop);

  // An emptied or flushed buffer keeps showing the last head value.
  always_comb begin
    w_head_nxt = r_head;
    if (!i_flush) begin
      if (i_push && w_drained)
        w_head_nxt = i_data;
      else if (w_count_nxt != '0)
        w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_nxt;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (i_push)
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_rd_ptr <= w_rd_nxt;
        r_count  <= w_count_nxt;
      end
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, fetch FSM and redirect/halt handling for decode
// FETCH_PERF_CNT_EN enables the fetch_count and stall_count counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              BUF_DEPTH  = 2,
  parameter logic [XLEN-1:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input logic                clk,
  input logic                reset_n,
  fetch_controller_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_nxt;
  logic             r_misalign;

  logic             w_redir;
  logic [XLEN-1:0]  w_redir_pc;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_is_halt;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_entry;

  // Redirects are meaningless before the first start, so IDLE drops them.
  assign w_redir    = bus.redirect_valid && (r_state != IDLE);
  assign w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_full     = (w_count == CNT_W'(BUF_DEPTH));
  assign w_pop      = bus.out_valid && bus.out_ready && !w_redir;
  assign w_push     = (r_state == RUN) && !w_redir && (!w_full || w_pop);
  assign w_is_halt  = (bus.imem_read_data == HALT_INSTR);
  assign w_entry    = '{instr: bus.imem_read_data, pc: r_pc};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = START_PC;
        end
      end
      RUN: begin
        if (w_redir) begin
          w_pc_nxt = w_redir_pc;
        end else if (w_push) begin
          if (w_is_halt)
            w_state_nxt = HALTED;
          else
            w_pc_nxt = r_pc + 32'd4;
        end
      end
      HALTED: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = START_PC;
        end else if (w_redir) begin
          w_state_nxt = RUN;
          w_pc_nxt    = w_redir_pc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pc       <= START_PC;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_redir && (bus.redirect_pc[1:0] != 2'b00))
        r_misalign <= 1'b1;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  (w_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.imem_address = r_pc[IMEM_ADDR_W+1:2];
  assign bus.out_valid    = (w_count != '0) && !w_redir;
  assign bus.out_instr    = w_head.instr;
  assign bus.out_pc       = w_head.pc;
  assign bus.halted       = (r_state == HALTED);
  assign bus.misalign_err = r_misalign;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_push)
        r_fetch_count <= r_fetch_count + 32'd1;
      if ((r_state == RUN) && w_full && !w_pop)
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.fetch_count = r_fetch_count;
  assign bus.stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed bench for fetch_controller against a combinational imem model
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam logic [31:0] HALT = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem [2048];
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_controller_if bus ();

  fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .BUF_DEPTH  (2),
    .HALT_INSTR (HALT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_read_data = mem[bus.imem_address];

  function automatic logic [31:0] word(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_instr"}, bus.out_instr, instr);
    check({tag, "_pc"}, bus.out_pc, pc);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = word(i);
    reset_n            = 1'b0;
    bus.start          = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", bus.out_instr, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_misalign", 32'(bus.misalign_err), 32'd0);
    check("rst_addr", 32'(bus.imem_address), 32'd0);
    reset_n = 1'b1;
    tick();

    // Streaming: A, B, C, D on consecutive cycles
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("run_empty_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_head($sformatf("stream%0d", k), word(k), 32'(4 * k));
    end

    // Back-pressure: restart at 0 via redirect, buffer saturates at address 2
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    #1;
    check("redir0_valid_forced", 32'(bus.out_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("stall_addr%0d", c), 32'(bus.imem_address), (c < 2) ? 32'(c) : 32'd2);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_head($sformatf("drain%0d", k), word(k), 32'(4 * k));
      tick();
    end

    // Redirect to 0x40 with a full buffer
    bus.out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("full_valid", 32'(bus.out_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    check("redir40_valid_forced", 32'(bus.out_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    check("redir40_flushed", 32'(bus.out_valid), 32'd0);
    tick();
    check_head("redir40_w16", word(16), 32'h40);
    tick();
    check_head("redir40_w17", word(17), 32'h44);

    // HALT at word 2, then start refetches from RESET_PC
    mem[2]             = HALT;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check_head("halt_a", word(0), 32'h0);
    tick();
    check_head("halt_b", word(1), 32'h4);
    tick();
    check_head("halt_instr", HALT, 32'h8);
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_addr", 32'(bus.imem_address), 32'd2);
    tick();
    check("halt_drained", 32'(bus.out_valid), 32'd0);
    check("halt_addr_hold", 32'(bus.imem_address), 32'd2);
    check("halt_flag_hold", 32'(bus.halted), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    mem[2]    = word(2);
    check("restart_halted", 32'(bus.halted), 32'd0);
    check("restart_addr", 32'(bus.imem_address), 32'd0);
    tick();
    check_head("restart_a", word(0), 32'h0);

    // Word-address wrap 2047 -> 0
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h1FFC;
    tick();
    bus.redirect_valid = 1'b0;
    check("wrap_addr_top", 32'(bus.imem_address), 32'd2047);
    tick();
    check_head("wrap_last", word(2047), 32'h1FFC);
    check("wrap_addr_zero", 32'(bus.imem_address), 32'd0);
    tick();
    check_head("wrap_next", word(0), 32'h2000);

    // Misaligned redirect target
    check("misalign_clear", 32'(bus.misalign_err), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    tick();
    bus.redirect_valid = 1'b0;
    check("misalign_set", 32'(bus.misalign_err), 32'd1);
    check("misalign_addr", 32'(bus.imem_address), 32'd16);
    tick();
    check_head("misalign_w16", word(16), 32'h40);
    tick();
    check("misalign_sticky", 32'(bus.misalign_err), 32'd1);

    // Asynchronous reset with two entries buffered
    bus.out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("prereset_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_valid", 32'(bus.out_valid), 32'd0);
    check("areset_halted", 32'(bus.halted), 32'd0);
    check("areset_misalign", 32'(bus.misalign_err), 32'd0);
    check("areset_addr", 32'(bus.imem_address), 32'd0);
    check("areset_instr", bus.out_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("areset_fetch_count", bus.fetch_count, 32'd0);
    check("areset_stall_count", bus.stall_count, 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
